// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one result bit per cycle.
// Optional: define MULDIV_EARLY_OUT_EN to bypass CALC/FIX on trivial operands.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         kill_i,
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] rs1_data_i,
  input  logic [N-1:0] rs2_data_i,
  input  logic [4:0]   rd_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0]     op_r;
  logic [4:0]     rd_r;
  logic [N-1:0]   a_abs, b_abs;
  logic           a_neg, b_neg;
  logic           dz_r, ovf_r;
  logic [2*N-1:0] acc;
  logic [N-1:0]   rem;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   wdata;

  logic [N-1:0]   min_neg;
  logic           a_sgn, b_sgn;
  logic           in_div, in_a_neg, in_b_neg;
  logic           in_dz, in_ovf;
  logic [N-1:0]   in_a_abs, in_b_abs;

  assign min_neg = {1'b1, {(N-1){1'b0}}};

  // operand signedness per RV32M op
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (funct3_i)
      3'b000, 3'b001,
      3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign in_div   = funct3_i[2];
  assign in_a_neg = a_sgn & rs1_data_i[N-1];
  assign in_b_neg = b_sgn & rs2_data_i[N-1];
  assign in_a_abs = in_a_neg ? -rs1_data_i : rs1_data_i;
  assign in_b_abs = in_b_neg ? -rs2_data_i : rs2_data_i;
  assign in_dz    = in_div & (rs2_data_i == '0);
  assign in_ovf   = in_div & ~funct3_i[0]
                  & (rs1_data_i == min_neg)
                  & (rs2_data_i == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic         early;
  logic [N-1:0] early_res;

  assign early = in_dz | in_ovf
               | (rs1_data_i == '0)
               | (rs2_data_i == '0);

  // result for operands that need no iteration
  always_comb begin
    early_res = '0;
    if (in_dz)
      early_res = funct3_i[1] ? rs1_data_i : '1;
    else if (in_ovf)
      early_res = funct3_i[1] ? '0 : min_neg;
  end
`endif

  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_sh, div_diff;
  logic           div_ge;
  logic [N-1:0]   rem_next, q_next;

  // one shift-add / shift-subtract step
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]}
             + (acc[0] ? {1'b0, a_abs} : '0);
    mul_next = {mul_sum, acc[N-1:1]};
    div_sh   = {rem, acc[N-1]};
    div_diff = div_sh - {1'b0, b_abs};
    div_ge   = ~div_diff[N];
    rem_next = div_ge ? div_diff[N-1:0] : div_sh[N-1:0];
    q_next   = {acc[N-2:0], div_ge};
  end

  logic [2*N-1:0] prod_s;
  logic [N-1:0]   quot_s, rem_s, a_orig;
  logic [N-1:0]   fix_res;

  // sign correction, result select and special cases
  always_comb begin
    prod_s  = (a_neg ^ b_neg) ? -acc : acc;
    quot_s  = (a_neg ^ b_neg) ? -acc[N-1:0] : acc[N-1:0];
    rem_s   = a_neg ? -rem : rem;
    a_orig  = a_neg ? -a_abs : a_abs;
    fix_res = '0;
    unique case (op_r)
      3'b000:  fix_res = prod_s[N-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_res = prod_s[2*N-1:N];
      3'b100,
      3'b101:  fix_res = quot_s;
      default: fix_res = rem_s;
    endcase
    if (op_r[2] && dz_r)
      fix_res = op_r[1] ? a_orig : '1;
    else if (op_r[2] && ovf_r)
      fix_res = op_r[1] ? '0 : min_neg;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n = state;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_n = early ? DONE : CALC;
`else
          state_n = CALC;
`endif
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (kill_i)
          state_n = IDLE;
        else if (cnt == CW'(N-1))
          state_n = FIX;
      end
      FIX: begin
        busy_o  = 1'b1;
        state_n = kill_i ? IDLE : DONE;
      end
      default: begin
        busy_o  = 1'b1;
        done_o  = ~kill_i;
        state_n = IDLE;
      end
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r  <= '0;
      rd_r  <= '0;
      a_abs <= '0;
      b_abs <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      dz_r  <= 1'b0;
      ovf_r <= 1'b0;
      acc   <= '0;
      rem   <= '0;
      cnt   <= '0;
      wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            op_r  <= funct3_i;
            rd_r  <= rd_i;
            a_abs <= in_a_abs;
            b_abs <= in_b_abs;
            a_neg <= in_a_neg;
            b_neg <= in_b_neg;
            dz_r  <= in_dz;
            ovf_r <= in_ovf;
            acc   <= in_div ? {{N{1'b0}}, in_a_abs}
                            : {{N{1'b0}}, in_b_abs};
            rem   <= '0;
            cnt   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            if (early) wdata <= early_res;
`endif
          end
        end
        CALC: begin
          if (!kill_i) begin
            cnt <= cnt + 1'b1;
            if (op_r[2]) begin
              acc[N-1:0] <= q_next;
              rem        <= rem_next;
            end else begin
              acc <= mul_next;
            end
          end
        end
        FIX: begin
          if (!kill_i) wdata <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign Reg_Write_o      = done_o & (rd_r != 5'd0);
  assign Write_Register_o = rd_r;
  assign Write_Data_o     = wdata;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Random and directed RV32M ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_i = '0;
  logic        busy_o, done_o, Reg_Write_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o;

  muldiv_unit #(.N(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .kill_i           (kill_i),
    .funct3_i         (funct3_i),
    .rs1_data_i       (rs1_data_i),
    .rs2_data_i       (rs2_data_i),
    .rd_i             (rd_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .Reg_Write_o      (Reg_Write_o),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_data = '0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    up = {32'd0, a} * {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (a == 0 || b == 0) return 1;
    if (f3 inside {3'd4, 3'd6} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
`endif
    if (f3 > 7) return 0;
    return 34;
  endfunction

  // scoreboard monitor: every done beat consumes one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (reset && done_o) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got data %0h expected no beat",
                 Write_Data_o);
      end else begin
        e = sb_q.pop_front();
        check("wdata", {32'd0, Write_Data_o}, {32'd0, e.data});
        check("wreg", {59'd0, Write_Register_o}, {59'd0, e.rd});
        check("regwrite", {63'd0, Reg_Write_o}, {63'd0, e.we});
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input int mid);
    exp_t e;
    int lat, bcnt;
    bit got;
    @(negedge clk);
    start_i = 1'b1;
    funct3_i = f3;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_i = rd;
    e.data = ref_op(f3, a, b);
    e.rd = rd;
    e.we = (rd != 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_i = 5'($urandom);
    lat = 1;
    bcnt = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy_o) bcnt++;
      if (done_o) begin
        got = 1;
        break;
      end
      if (mid != 0 && lat == mid) begin
        start_i = 1'b1;
        funct3_i = 3'($urandom);
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
      lat++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done expected done_o");
    end else begin
      check("latency", 64'(lat), 64'(exp_lat(f3, a, b)));
      check("busy_cycles", 64'(bcnt), 64'(exp_lat(f3, a, b)));
    end
    last_data = e.data;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 reset = 1'b0;
    #20;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_regwrite", {63'd0, Reg_Write_o}, 64'd0);
    check("rst_wreg", {59'd0, Write_Register_o}, 64'd0);
    check("rst_wdata", {32'd0, Write_Data_o}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd11, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd14, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd15, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0);
    run_op(3'd0, 32'd123, 32'd456, 5'd0, 0);
    run_op(3'd4, 32'd1000, 32'd3, 5'd18, 5);

    // abort mid-CALC: no beat, result register untouched
    @(negedge clk);
    start_i = 1'b1;
    funct3_i = 3'd4;
    rs1_data_i = 32'd999;
    rs2_data_i = 32'd4;
    rd_i = 5'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    check("kill_done", {63'd0, done_o}, 64'd0);
    @(posedge clk);
    #1 kill_i = 1'b0;
    check("kill_busy", {63'd0, busy_o}, 64'd0);
    check("kill_wdata", {32'd0, Write_Data_o}, {32'd0, last_data});
    run_op(3'd7, 32'd999, 32'd4, 5'd19, 0);

    // async reset mid-CALC
    run_op(3'd0, 32'd3, 32'd5, 5'd20, 0);
    @(negedge clk);
    start_i = 1'b1;
    funct3_i = 3'd0;
    rs1_data_i = 32'd9;
    rs2_data_i = 32'd9;
    rd_i = 5'd21;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_done", {63'd0, done_o}, 64'd0);
    check("arst_regwrite", {63'd0, Reg_Write_o}, 64'd0);
    check("arst_wreg", {59'd0, Write_Register_o}, 64'd0);
    check("arst_wdata", {32'd0, Write_Data_o}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 30; k++)
      run_op(3'($urandom), pick(), pick(), 5'($urandom), 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
